// File: rtl/mac_requant_drain_pkg.sv
// Shared constants, state encoding and saturation limits for the MAC requantise/drain stage.
package mac_requant_drain_pkg;

   localparam int unsigned LANES   = 16;
   localparam int unsigned IN_W    = 17;
   localparam int unsigned OUT_W   = 8;
   localparam int unsigned LANE_W  = 4;
   localparam int unsigned SHIFT_W = 4;

   localparam int SAT_MAX = 127;
   localparam int SAT_MIN = -128;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   typedef enum logic [1:0] {
      IDLE,
      QUANT,
      DRAIN
   } state_t;

endpackage

// File: rtl/mac_requant_drain_if.sv
// Capture bus from the MAC core plus the quantised output stream to the activation buffer.
interface mac_requant_drain_if;
   import mac_requant_drain_pkg::*;

   logic                    capture;
   logic [LANES*IN_W-1:0]   din;
   logic [SHIFT_W-1:0]      shift;
   logic                    relu_en;
   logic                    busy;
   logic                    out_valid;
   logic                    out_ready;
   logic [OUT_W-1:0]        out_data;
   logic [LANE_W-1:0]       out_lane;
   logic                    out_last;
   logic                    out_sat;
   logic                    overflow;

   // Producer/consumer side: drives the capture bus and the ready, watches the stream.
   modport master (
      output capture, din, shift, relu_en, out_ready,
      input  busy, out_valid, out_data, out_lane, out_last, out_sat, overflow
   );

   // Stage side.
   modport slave (
      input  capture, din, shift, relu_en, out_ready,
      output busy, out_valid, out_data, out_lane, out_last, out_sat, overflow
   );

endinterface

// File: rtl/mac_requant_drain_requant_lane.sv
// One lane of requantisation: optional ReLU, round-half-up arithmetic right shift, signed 8-bit clamp.
module requant_lane
   import mac_requant_drain_pkg::*;
(
   input  logic [IN_W-1:0]    i_x,
   input  logic [SHIFT_W-1:0] i_shift,
   input  logic               i_relu_en,
   output logic [OUT_W-1:0]   o_q,
   output logic               o_sat
);

   // One guard bit keeps the rounding add from overflowing for any 17-bit input.
   localparam int unsigned XW = IN_W + 1;
   localparam logic signed [XW-1:0] L_ONE = XW'(1);
   localparam logic signed [XW-1:0] L_MAX = XW'(SAT_MAX);
   localparam logic signed [XW-1:0] L_MIN = XW'(SAT_MIN);

   logic signed [XW-1:0] w_x;
   logic signed [XW-1:0] w_rnd;
   logic signed [XW-1:0] w_sh;

   // ReLU, rounding shift and saturation for a single lane.
   always_comb begin
      w_x   = {i_x[IN_W-1], i_x};
      w_rnd = w_x;
      w_sh  = w_x;
      o_q   = '0;
      o_sat = 1'b0;
      if (i_relu_en && w_x[XW-1]) begin
         w_x = '0;
      end
      if (i_shift != '0) begin
         w_rnd = w_x + (L_ONE << (i_shift - SHIFT_W'(1)));
         w_sh  = w_rnd >>> i_shift;
      end else begin
         w_sh  = w_x;
      end
      if (w_sh > L_MAX) begin
         o_q   = L_MAX[OUT_W-1:0];
         o_sat = 1'b1;
      end else if (w_sh < L_MIN) begin
         o_q   = L_MIN[OUT_W-1:0];
         o_sat = 1'b1;
      end else begin
         o_q   = w_sh[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/mac_requant_drain.sv
// Captures a 16-lane MAC result set, quantises all lanes in one cycle and drains them one per handshake.
module mac_requant_drain
   import mac_requant_drain_pkg::*;
(
   input  logic                Clk,
   input  logic                reset,
   mac_requant_drain_if.slave  bus
);

   state_t                         r_state;
   logic [LANES*IN_W-1:0]          r_din;
   logic [SHIFT_W-1:0]             r_shift;
   logic                           r_relu;
   logic [LANES-1:0][OUT_W-1:0]    r_q;
   logic [LANES-1:0]               r_sat;
   logic [LANE_W-1:0]              r_cnt;
   logic                           r_busy;
   logic                           r_valid;
   logic [OUT_W-1:0]               r_data;
   logic                           r_last;
   logic                           r_sat_o;
   logic                           r_ovf;

   logic [LANES-1:0][OUT_W-1:0]    w_q;
   logic [LANES-1:0]               w_sat;
   logic                           w_hs;
   logic                           w_hs_last;
   logic [LANE_W-1:0]              w_nxt;

   assign w_hs      = r_valid & bus.out_ready;
   assign w_hs_last = w_hs & (r_cnt == LAST_LANE);
   assign w_nxt     = r_cnt + LANE_W'(1);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      requant_lane u_lane (
         .i_x       (r_din[g*IN_W +: IN_W]),
         .i_shift   (r_shift),
         .i_relu_en (r_relu),
         .o_q       (w_q[g]),
         .o_sat     (w_sat[g])
      );
   end

   // Control FSM with registered stream outputs; a capture on the final handshake chains straight into QUANT.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_din   <= '0;
         r_shift <= '0;
         r_relu  <= 1'b0;
         r_q     <= '0;
         r_sat   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_sat_o <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.capture) begin
                  r_din   <= bus.din;
                  r_shift <= bus.shift;
                  r_relu  <= bus.relu_en;
                  r_busy  <= 1'b1;
                  r_state <= QUANT;
               end
            end
            QUANT: begin
               r_q     <= w_q;
               r_sat   <= w_sat;
               r_cnt   <= '0;
               r_valid <= 1'b1;
               r_data  <= w_q[0];
               r_sat_o <= w_sat[0];
               r_last  <= 1'b0;
               r_state <= DRAIN;
            end
            DRAIN: begin
               if (w_hs_last) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  if (bus.capture) begin
                     r_din   <= bus.din;
                     r_shift <= bus.shift;
                     r_relu  <= bus.relu_en;
                     r_state <= QUANT;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end else if (w_hs) begin
                  r_cnt   <= w_nxt;
                  r_data  <= r_q[w_nxt];
                  r_sat_o <= r_sat[w_nxt];
                  r_last  <= (w_nxt == LAST_LANE);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
         if (bus.capture && ((r_state == QUANT) || ((r_state == DRAIN) && !w_hs_last))) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_lane  = r_cnt;
   assign bus.out_last  = r_last;
   assign bus.out_sat   = r_sat_o;
   assign bus.overflow  = r_ovf;

endmodule
